// File: rtl/vga_out_stage.sv
// rtl/vga_out_stage.sv - two-stage VGA output register with brightness scaling and frame-synchronous fade
module vga_out_stage #(
  parameter int COLOR_BITS      = 2,
  parameter int BRIGHT_BITS     = 3,
  parameter int FRAMES_PER_STEP = 4,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    active,
  input  logic                    hsync,
  input  logic                    vsync,
  input  logic [COLOR_BITS-1:0]   red_pixel,
  input  logic [COLOR_BITS-1:0]   green_pixel,
  input  logic [COLOR_BITS-1:0]   blue_pixel,
  input  logic [BRIGHT_BITS:0]    bright_target,
  output logic [3*COLOR_BITS-1:0] vga_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic [BRIGHT_BITS:0]    bright_cur,
  output logic                    fade_busy
);

  localparam int PW = COLOR_BITS + BRIGHT_BITS + 1;
  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0]        L_LAST  = CW'(FRAMES_PER_STEP - 1);
  localparam logic [BRIGHT_BITS:0] L_UNITY = {1'b1, {BRIGHT_BITS{1'b0}}};
  localparam logic                 L_SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_STEP} state_t;

  logic                    r_s1_active;
  logic                    r_s1_hsync;
  logic                    r_s1_vsync;
  logic                    r_s1_vsync_d;
  logic [COLOR_BITS-1:0]   r_s1_red;
  logic [COLOR_BITS-1:0]   r_s1_green;
  logic [COLOR_BITS-1:0]   r_s1_blue;
  logic [3*COLOR_BITS-1:0] r_vga;
  logic                    r_hsync_out;
  logic                    r_vsync_out;
  logic [BRIGHT_BITS:0]    r_bright_cur;
  logic [CW-1:0]           r_frame_cnt;
  state_t                  r_state;

  logic [BRIGHT_BITS:0]    w_tgt;
  logic [BRIGHT_BITS:0]    w_next_bright;
  logic                    w_frame_start;

  // Upper product bits can never be set for legal inputs; the clamp keeps the result bounded anyway.
  function automatic logic [COLOR_BITS-1:0] scale(input logic [COLOR_BITS-1:0] pix,
                                                  input logic [BRIGHT_BITS:0]  br);
    logic [PW-1:0] prod;
    logic [PW-1:0] shifted;
    prod    = PW'(pix) * PW'(br);
    shifted = prod >> BRIGHT_BITS;
    if (shifted > PW'({COLOR_BITS{1'b1}}))
      scale = {COLOR_BITS{1'b1}};
    else
      scale = shifted[COLOR_BITS-1:0];
  endfunction

  assign w_tgt         = (bright_target > L_UNITY) ? L_UNITY : bright_target;
  assign w_frame_start = (r_s1_vsync != L_SYNC_IDLE) && (r_s1_vsync_d == L_SYNC_IDLE);

  always_comb begin
    w_next_bright = r_bright_cur;
    if (w_tgt > r_bright_cur)
      w_next_bright = r_bright_cur + 1'b1;
    else if (w_tgt < r_bright_cur)
      w_next_bright = r_bright_cur - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_active  <= 1'b0;
      r_s1_hsync   <= L_SYNC_IDLE;
      r_s1_vsync   <= L_SYNC_IDLE;
      r_s1_vsync_d <= L_SYNC_IDLE;
      r_s1_red     <= '0;
      r_s1_green   <= '0;
      r_s1_blue    <= '0;
      r_vga        <= '0;
      r_hsync_out  <= L_SYNC_IDLE;
      r_vsync_out  <= L_SYNC_IDLE;
    end else begin
      r_s1_active  <= active;
      r_s1_hsync   <= hsync;
      r_s1_vsync   <= vsync;
      r_s1_vsync_d <= r_s1_vsync;
      r_s1_red     <= red_pixel;
      r_s1_green   <= green_pixel;
      r_s1_blue    <= blue_pixel;
      r_vga        <= r_s1_active ? {scale(r_s1_blue,  r_bright_cur),
                                     scale(r_s1_green, r_bright_cur),
                                     scale(r_s1_red,   r_bright_cur)} : '0;
      r_hsync_out  <= r_s1_hsync;
      r_vsync_out  <= r_s1_vsync;
    end
  end

  // Target changes are honoured at every STEP; the frame counter keeps running through them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_frame_cnt  <= '0;
      r_bright_cur <= L_UNITY;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_frame_cnt <= '0;
          if (w_tgt != r_bright_cur) r_state <= S_COUNT;
        end
        S_COUNT: begin
          if (w_tgt == r_bright_cur) begin
            r_frame_cnt <= '0;
            r_state     <= S_IDLE;
          end else if (w_frame_start) begin
            if (r_frame_cnt == L_LAST) begin
              r_frame_cnt <= '0;
              r_state     <= S_STEP;
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        S_STEP: begin
          r_bright_cur <= w_next_bright;
          r_state      <= (w_next_bright == w_tgt) ? S_IDLE : S_COUNT;
        end
        default: begin
          r_state     <= S_IDLE;
          r_frame_cnt <= '0;
        end
      endcase
    end
  end

  assign vga_out    = r_vga;
  assign hsync_out  = r_hsync_out;
  assign vsync_out  = r_vsync_out;
  assign bright_cur = r_bright_cur;
  assign fade_busy  = (w_tgt != r_bright_cur);

endmodule
